// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte stream to instruction-memory word writes; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte
module imem_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        COMMIT,
        DONE,
        ERR
    } state_t;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t TAIL = CHK;
`else
    localparam state_t TAIL = COMMIT;
`endif
    state_t state, state_n;
    logic [7:0] len_lo;
    logic [15:0] n;
    logic [1:0] byte_cnt;
    logic [ADDR_WIDTH:0] word_cnt;
    logic [31:0] asm_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;
`endif
    logic acc, last_byte, last_word, re_arm;
    logic [15:0] len_in;
    assign in_ready  = state != COMMIT && state != DONE && state != ERR;
    assign core_hold = state != DONE;
    assign done      = state == DONE;
    assign error     = state == ERR;
    assign acc       = in_valid & in_ready;
    assign len_in    = {in_byte, len_lo};
    assign last_byte = state == DATA && byte_cnt == 2'd3;
    assign last_word = 16'(word_cnt) + 16'd1 == n;
    assign re_arm    = start && (state == DONE || state == ERR);
    always_ff @(posedge clk)
        state <= reset ? LEN0 : state_n;
    always_comb begin
        state_n = state;
        case (state)
            LEN0:    state_n = acc ? LEN1 : LEN0;
            LEN1:    if (acc) state_n = len_in > 16'(MEM_WORDS) ? ERR : len_in == 16'd0 ? TAIL : DATA;
            DATA:    state_n = acc && last_byte && last_word ? TAIL : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:     if (acc) state_n = in_byte == xor_acc ? COMMIT : ERR;
`endif
            COMMIT:  state_n = DONE;
            DONE:    state_n = start ? LEN0 : DONE;
            ERR:     state_n = start ? LEN0 : ERR;
            default: state_n = LEN0;
        endcase
    end
    // A reset edge also drops any write the same edge would have launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo    <= '0;
            n         <= '0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            asm_word  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc   <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (acc && state == LEN0) len_lo <= in_byte;
            if (acc && state == LEN1) n <= len_in;
            if (acc && state == DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
                asm_word <= {in_byte, asm_word[31:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_acc  <= xor_acc ^ in_byte;
`endif
                if (last_byte) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                    mem_wdata <= {in_byte, asm_word[31:8]};
                    word_cnt  <= word_cnt + 1'b1;
                end
            end
            if (re_arm) begin
                byte_cnt <= '0;
                word_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_acc  <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed load scenarios with a write log captured on the falling edge
module tb_imem_loader;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic in_ready, mem_we, core_hold, done, error;
    logic [5:0] mem_addr;
    logic [31:0] mem_wdata;
    int checks = 0, errors = 0;
    int wr_cnt = 0, run = 0, max_run = 0, base = 0;
    logic [5:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [7:0] s1 [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    always #5 clk = ~clk;
    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .done(done), .error(error)
    );
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt++;
            run++;
            if (run > max_run) max_run = run;
        end else run = 0;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte = b;
        step();
        in_valid = 1'b0;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    initial begin
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_core_hold", core_hold, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h01); send(8'h00); send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        check("ck_we", mem_we, 1);
        check("ck_addr", mem_addr, 0);
        check("ck_data", mem_wdata, 32'h11223344);
        check("ck_ready_chk", in_ready, 1);
        send(8'h44);
        check("ck_commit_done", done, 0);
        check("ck_commit_we", mem_we, 0);
        step();
        check("ck_done", done, 1);
        check("ck_hold", core_hold, 0);
        pulse_start();
        base = wr_cnt;
        send(8'h01); send(8'h00); send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        send(8'h45);
        check("ckbad_error", error, 1);
        check("ckbad_done", done, 0);
        check("ckbad_hold", core_hold, 1);
        step();
        check("ckbad_writes", wr_cnt - base, 1);
        check("ckbad_wdata", wr_data[base], 32'h11223344);
        pulse_start();
        check("ck0_ready", in_ready, 1);
        send(8'h00); send(8'h00);
        check("ck0_wait_chk", in_ready, 1);
        check("ck0_not_done", done, 0);
        send(8'h00);
        step();
        check("ck0_done", done, 1);
`else
        for (int i = 0; i < 6; i++) send(s1[i]);
        check("s1_we0", mem_we, 1);
        check("s1_addr0", mem_addr, 0);
        check("s1_data0", mem_wdata, 32'h00500093);
        for (int i = 6; i < 9; i++) begin
            send(s1[i]);
            check("s1_we_gap", mem_we, 0);
        end
        send(s1[9]);
        check("s1_we1", mem_we, 1);
        check("s1_addr1", mem_addr, 1);
        check("s1_data1", mem_wdata, 32'h00A00113);
        check("s1_commit_done", done, 0);
        check("s1_commit_hold", core_hold, 1);
        check("s1_commit_ready", in_ready, 0);
        step();
        check("s1_done", done, 1);
        check("s1_hold", core_hold, 0);
        check("s1_we_off", mem_we, 0);
        check("s1_ready", in_ready, 0);
        check("s1_writes", wr_cnt, 2);
        base = wr_cnt;
        pulse_start();
        check("s2_ready", in_ready, 1);
        check("s2_done_clr", done, 0);
        check("s2_hold", core_hold, 1);
        for (int i = 0; i < 10; i++) begin
            send(s1[i]);
            step();
        end
        check("s2_done", done, 1);
        check("s2_writes", wr_cnt - base, 2);
        check("s2_addr0", wr_addr[base], 0);
        check("s2_data0", wr_data[base], 32'h00500093);
        check("s2_addr1", wr_addr[base+1], 1);
        check("s2_data1", wr_data[base+1], 32'h00A00113);
        check("s2_we_pulse", max_run, 1);
        base = wr_cnt;
        pulse_start();
        send(8'h41); send(8'h00);
        check("s3_error", error, 1);
        check("s3_ready", in_ready, 0);
        check("s3_hold", core_hold, 1);
        check("s3_done", done, 0);
        in_valid = 1'b1;
        in_byte = 8'h00;
        step();
        step();
        in_valid = 1'b0;
        check("s3_error_held", error, 1);
        check("s3_no_write", wr_cnt - base, 0);
        pulse_start();
        check("s3_rearm_ready", in_ready, 1);
        check("s3_rearm_error", error, 0);
        check("s3_rearm_hold", core_hold, 1);
        send(8'h40); send(8'h00);
        check("s3_max_ok_error", error, 0);
        check("s3_max_ok_ready", in_ready, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("s4_ready", in_ready, 1);
        base = wr_cnt;
        send(8'h00); send(8'h00);
        check("s4_we", mem_we, 0);
        check("s4_commit_done", done, 0);
        check("s4_commit_ready", in_ready, 0);
        step();
        check("s4_done", done, 1);
        check("s4_hold", core_hold, 0);
        step();
        check("s4_no_write", wr_cnt - base, 0);
        pulse_start();
        for (int i = 0; i < 9; i++) send(s1[i]);
        reset = 1'b1;
        in_valid = 1'b1;
        in_byte = s1[9];
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        check("s6_rst_we", mem_we, 0);
        check("s6_rst_addr", mem_addr, 0);
        check("s6_rst_ready", in_ready, 1);
        check("s6_rst_hold", core_hold, 1);
        base = wr_cnt;
        for (int i = 0; i < 10; i++) send(s1[i]);
        step();
        check("s6_done", done, 1);
        check("s6_writes", wr_cnt - base, 2);
        check("s6_addr0", wr_addr[base], 0);
        check("s6_data0", wr_data[base], 32'h00500093);
        check("s6_data1", wr_data[base+1], 32'h00A00113);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
